// File: rtl/acc_feed.sv
// -----------------------------------------------------------------------------
// acc_feed
//
// Input staging block that sits directly upstream of the `acc` accumulator.
// It accepts samples over a valid/ready stream and buffers them in a small
// FIFO. It then issues at most one registered sample per clock on the x/en pair.
// Issue can be stalled with `hold`. The block also flags the last sample of each
// fixed-length burst.
//
// Parameters
//   WIDTH  sample width, must match the accumulator x width
//   DEPTH  FIFO entries, power of two, >= 2
//   BURST  samples per burst, 1..65535
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     incoming sample
//   in_valid    in_data is valid
//   in_ready    FIFO can accept a sample (!full, from the occupancy register)
//   hold        suppress issue while high; the FIFO keeps filling
//   x           registered sample to the accumulator
//   en          registered; x carries a new sample this cycle
//   burst_done  registered pulse alongside the en of the BURST-th sample
//   level       current FIFO occupancy
// -----------------------------------------------------------------------------
module acc_feed #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hold,
  output logic [WIDTH-1:0]           x,
  output logic                       en,
  output logic                       burst_done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [15:0] LAST_CNT = 16'(BURST - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [15:0]      cnt;
  logic             push;
  logic             pop;

  // A full FIFO refuses input even when it pops in the same cycle. This keeps
  // in_ready a function of the occupancy register alone, so there is no
  // combinational path from hold to in_ready.
  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !hold && (level != '0);

  // NOTE: the storage array has no reset. Only the pointers and the occupancy
  // count define which entries are live, so clearing the array would add reset
  // fan-out without changing any behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: every register in this block uses non-blocking assignment. Each
  // read in this block then sees the value from before the edge, so a push
  // and a pop in the same cycle update level consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      x          <= '0;
      en         <= 1'b0;
      burst_done <= 1'b0;
      cnt        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (pop) begin
        // There is no bypass path. An entry is issued only after it has been
        // written, so the minimum latency from push to en is one edge.
        x      <= mem[rd_ptr];
        en     <= 1'b1;
        rd_ptr <= rd_ptr + PW'(1);
        if (cnt == LAST_CNT) begin
          cnt        <= '0;
          burst_done <= 1'b1;
        end else begin
          cnt        <= cnt + 16'd1;
          burst_done <= 1'b0;
        end
      end else begin
        // x keeps its last value. Only en tells the accumulator whether x
        // carries a new sample.
        en         <= 1'b0;
        burst_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_feed.sv
// -----------------------------------------------------------------------------
// tb_acc_feed
//
// Self-checking bench for acc_feed (WIDTH=32, DEPTH=4, BURST=16). It applies
// table-driven vectors for streaming and fill/stall. Hand-written sequences
// cover reset, the burst boundary and pointer wrap-around.
// -----------------------------------------------------------------------------
module tb_acc_feed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic [31:0] x;
  logic        en;
  logic        burst_done;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  acc_feed #(.WIDTH(32), .DEPTH(4), .BURST(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .x          (x),
    .en         (en),
    .burst_done (burst_done),
    .level      (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        h;
    logic        exp_en;
    logic [31:0] exp_x;
    logic [2:0]  exp_level;
    logic        exp_ready;
    logic        exp_bd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and return 1 time unit later. Inputs are driven and
  // outputs are read at this point, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int pushed, issued, hold_left, cycles, bd_count;
    bit held_done, fire;
    logic [31:0] data;

    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    hold     = 1'b0;

    // ---------------- reset values ----------------
    step();
    step();
    check("rst_en",    en,         0);
    check("rst_x",     x,          0);
    check("rst_level", level,      0);
    check("rst_ready", in_ready,   1);
    check("rst_bd",    burst_done, 0);
    rst_n = 1'b1;

    // Fill to 4 under hold, then pop once so that level = 3 with en = 1.
    hold     = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h11 * (i + 1);
      step();
    end
    check("pre_full_ready", in_ready, 0);
    in_valid = 1'b0;
    hold     = 1'b0;
    step();
    check("pre_level", level, 3);
    check("pre_en",    en,    1);
    check("pre_x",     x,     32'h11);

    // Mid-cycle reset: the outputs must clear without waiting for an edge.
    rst_n = 1'b0;
    #1;
    check("async_en",    en,         0);
    check("async_x",     x,          0);
    check("async_level", level,      0);
    check("async_ready", in_ready,   1);
    check("async_bd",    burst_done, 0);
    #1;
    rst_n = 1'b1;

    in_valid = 1'b1;
    in_data  = 32'hA5;
    step();
    check("a5_push_en",    en,    0);
    check("a5_push_level", level, 1);
    in_valid = 1'b0;
    step();
    check("a5_pop_en", en, 1);
    check("a5_pop_x",  x,  32'hA5);

    // ---------------- table: streaming then fill/stall ----------------
    //         v   d   h   en  x     lvl rdy bd
    vecs[0]  = '{1, 1,  0, 0, 32'hA5, 1, 1, 0};
    vecs[1]  = '{1, 2,  0, 1, 1,      1, 1, 0};
    vecs[2]  = '{1, 3,  0, 1, 2,      1, 1, 0};
    vecs[3]  = '{0, 0,  0, 1, 3,      0, 1, 0};
    vecs[4]  = '{0, 0,  0, 0, 3,      0, 1, 0};
    vecs[5]  = '{1, 10, 1, 0, 3,      1, 1, 0};
    vecs[6]  = '{1, 11, 1, 0, 3,      2, 1, 0};
    vecs[7]  = '{1, 12, 1, 0, 3,      3, 1, 0};
    vecs[8]  = '{1, 13, 1, 0, 3,      4, 0, 0};
    vecs[9]  = '{1, 14, 1, 0, 3,      4, 0, 0};
    vecs[10] = '{1, 14, 0, 1, 10,     3, 1, 0};
    vecs[11] = '{1, 14, 0, 1, 11,     3, 1, 0};
    vecs[12] = '{0, 0,  0, 1, 12,     2, 1, 0};
    vecs[13] = '{0, 0,  0, 1, 13,     1, 1, 0};
    vecs[14] = '{0, 0,  0, 1, 14,     0, 1, 0};
    vecs[15] = '{0, 0,  0, 0, 14,     0, 1, 0};

    acc = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      hold     = vecs[i].h;
      step();
      check($sformatf("vec%0d_en", i),    en,         vecs[i].exp_en);
      check($sformatf("vec%0d_x", i),     x,          vecs[i].exp_x);
      check($sformatf("vec%0d_level", i), level,      vecs[i].exp_level);
      check($sformatf("vec%0d_ready", i), in_ready,   vecs[i].exp_ready);
      check($sformatf("vec%0d_bd", i),    burst_done, vecs[i].exp_bd);
      if (i < 5 && en) acc += int'(x);
    end
    check("stream_acc_sum", acc, 6);

    // ---------------- burst boundary with a 3-cycle hold ----------------
    in_valid = 1'b0;
    hold     = 1'b0;
    do_reset();
    pushed    = 0;
    issued    = 0;
    hold_left = 0;
    held_done = 0;
    cycles    = 0;
    bd_count  = 0;
    while (issued < 33 && cycles < 300) begin
      in_valid = (pushed < 33);
      in_data  = 32'(100 + pushed);
      hold     = (hold_left > 0);
      fire     = in_valid && in_ready;
      step();
      cycles++;
      if (fire) pushed++;
      if (hold_left > 0) hold_left--;
      if (en) begin
        issued++;
        check($sformatf("burst_x%0d", issued),  x,          32'(100 + issued - 1));
        check($sformatf("burst_bd%0d", issued), burst_done, (issued % 16) == 0);
        if (burst_done) bd_count++;
        if (issued == 10 && !held_done) begin
          hold_left = 3;
          held_done = 1;
        end
      end else begin
        check("burst_idle_bd", burst_done, 0);
      end
    end
    check("burst_issued", issued,   33);
    check("burst_pulses", bd_count, 2);
    in_valid = 1'b0;
    hold     = 1'b0;

    // ---------------- pointer wrap ----------------
    do_reset();
    for (int i = 0; i < 9; i++) begin
      data     = $urandom;
      in_valid = 1'b1;
      in_data  = data;
      step();
      check($sformatf("wrap%0d_push_level", i), level, 1);
      check($sformatf("wrap%0d_push_en", i),    en,    0);
      in_valid = 1'b0;
      step();
      check($sformatf("wrap%0d_en", i),    en,    1);
      check($sformatf("wrap%0d_x", i),     x,     data);
      check($sformatf("wrap%0d_level", i), level, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
